// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: state-decoded datapath controls, memory-ready
// handshake with a bounded wait, and a one-cycle fault state for illegal ops or timeouts.
module multicycle_control_fsm #(
  parameter int width    = 6,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] Op,
  input  logic [width-1:0] Funct,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             JAL,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       Fault,
  output logic [3:0]       State
);

  // state  | meaning
  // 0-2    | IDLE, FETCH (IR load, PC+4), DECODE (branch target precompute)
  // 3-6    | MEMADR, MEMRD, MEMWB, MEMWR        7-8   | REXEC, RWB
  // 9-14   | BEQ, ADDIEX, ADDIWB, JUMP, JALS, JR  15  | FAULT (one cycle, cause on Fault)
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_REXEC  = 4'd7,
    S_RWB    = 4'd8,  S_BEQ    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12, S_JALS   = 4'd13, S_JR     = 4'd14, S_FAULT  = 4'd15
  } state_t;

  localparam logic [width-1:0] OP_RTYPE = width'(6'b000000);
  localparam logic [width-1:0] OP_LW    = width'(6'b100011);
  localparam logic [width-1:0] OP_SW    = width'(6'b101011);
  localparam logic [width-1:0] OP_BEQ   = width'(6'b000100);
  localparam logic [width-1:0] OP_ADDI  = width'(6'b001000);
  localparam logic [width-1:0] OP_J     = width'(6'b000010);
  localparam logic [width-1:0] OP_JAL   = width'(6'b000011);
  localparam logic [width-1:0] FN_JR    = width'(6'b001000);

  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam bit         TIMEOUT_EN    = (WAIT_MAX != 0);
  localparam logic [4:0] WAIT_LAST     = 5'(WAIT_MAX - 1);

  state_t     r_state;
  logic [4:0] r_wait_cnt;
  logic [1:0] r_fault_cause;
  logic       w_wait_state;
  logic       w_timeout;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // A ready on the final allowed cycle still completes the access.
  assign w_timeout    = TIMEOUT_EN && w_wait_state && !MemReady && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= 5'd0;
      r_fault_cause <= 2'b00;
    end else begin
      r_wait_cnt <= (w_wait_state && !MemReady) ? r_wait_cnt + 5'd1 : 5'd0;
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          r_fault_cause <= 2'b00;
          if (MemReady) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault_cause <= FAULT_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (Op == OP_LW || Op == OP_SW) r_state <= S_MEMADR;
          else if (Op == OP_RTYPE)        r_state <= (Funct == FN_JR) ? S_JR : S_REXEC;
          else if (Op == OP_BEQ)          r_state <= S_BEQ;
          else if (Op == OP_ADDI)         r_state <= S_ADDIEX;
          else if (Op == OP_J)            r_state <= S_JUMP;
          else if (Op == OP_JAL)          r_state <= S_JALS;
          else begin
            r_state       <= S_FAULT;
            r_fault_cause <= FAULT_ILLEGAL;
          end
        end
        S_MEMADR: r_state <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD, S_MEMWR: begin
          if (MemReady) begin
            r_state <= (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
          end else if (w_timeout) begin
            r_state       <= S_FAULT;
            r_fault_cause <= FAULT_TIMEOUT;
          end
        end
        S_REXEC:  r_state <= S_RWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JUMP, S_JALS, S_JR, S_FAULT: r_state <= S_FETCH;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    JAL         = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    Fault       = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      S_JALS: begin
        PCWrite  = 1'b1;
        PCSrc    = 2'b10;
        RegWrite = 1'b1;
        JAL      = 1'b1;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b11;
      end
      S_FAULT: Fault = r_fault_cause;
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each stimulus cycle queues the expected
// state/output word, and a negedge monitor pops and compares it against the DUT.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, JAL, ALUSrcA;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, Fault;
  logic [3:0] State;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, JALOP = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000;

  multicycle_control_fsm #(.width(6), .WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .JAL(JAL), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Fault(Fault), .State(State)
  );

  typedef struct {
    logic [22:0] exp;
    int          id;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  step_no = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a given state, taken from the control table.
  function automatic logic [22:0] exp_vec(input logic [3:0] st, input logic mr, input logic [1:0] flt);
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, jl, asa;
    logic [1:0] pcs, asb, aop, f;
    {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, jl, asa} = '0;
    {pcs, asb, aop, f} = '0;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iord = 1; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; rdst = 1; end
      4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin pcw = 1; pcs = 2'b10; end
      4'd13: begin pcw = 1; pcs = 2'b10; rw = 1; jl = 1; end
      4'd14: begin pcw = 1; pcs = 2'b11; end
      4'd15: f = flt;
      default: ;
    endcase
    return {st, pcw, pcwc, pcs, iord, mrd, mwr, irw, rdst, m2r, rw, jl, asa, asb, aop, f};
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic mr, input logic [3:0] st, input logic [1:0] flt);
    sb_t item;
    reset    = rst;
    Op       = op;
    Funct    = fn;
    MemReady = mr;
    item.exp = exp_vec(st, mr, flt);
    item.id  = step_no;
    sbq.push_back(item);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] st);
    cyc(1'b0, op, fn, 1'b1, st, 2'b00);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_t item;
      logic [22:0] act;
      item = sbq.pop_front();
      act = {State, PCWrite, PCWriteCond, PCSrc, IorD, MemRead, MemWrite, IRWrite,
             RegDst, MemtoReg, RegWrite, JAL, ALUSrcA, ALUSrcB, ALUOp, Fault};
      checks++;
      if (act !== item.exp) begin
        errors++;
        $display("FAIL step%0d: actual state=%0d word=%h, required state=%0d word=%h",
                 item.id, act[22:19], act, item.exp[22:19], item.exp);
      end
    end
  end

  initial begin
    reset = 1'b1; Op = '0; Funct = '0; MemReady = 1'b0;
    @(posedge clk); #1;
    cyc(1, RT, 0, 0, 0, 0);
    cyc(0, RT, 0, 0, 0, 0);
    // lw with memory always ready
    run(LW, 0, 1); run(LW, 0, 2); run(LW, 0, 3); run(LW, 0, 4); run(LW, 0, 5);
    // slow fetch, then R-type add
    repeat (3) cyc(0, RT, FN_ADD, 0, 1, 0);
    run(RT, FN_ADD, 1); run(RT, FN_ADD, 2); run(RT, FN_ADD, 7); run(RT, FN_ADD, 8);
    // illegal opcode
    run(BAD, 0, 1); run(BAD, 0, 2); cyc(0, BAD, 0, 1, 15, 2'b01);
    // sw timing out in MEMWR
    run(SW, 0, 1); run(SW, 0, 2); run(SW, 0, 3);
    repeat (4) cyc(0, SW, 0, 0, 6, 0);
    cyc(0, SW, 0, 0, 15, 2'b10);
    // sw ready on the last allowed cycle
    run(SW, 0, 1); run(SW, 0, 2); run(SW, 0, 3);
    repeat (3) cyc(0, SW, 0, 0, 6, 0);
    run(SW, 0, 6);
    // jr, beq, j, jal, addi
    run(RT, FN_JR, 1); run(RT, FN_JR, 2); run(RT, FN_JR, 14);
    run(BEQ, 0, 1); run(BEQ, 0, 2); run(BEQ, 0, 9);
    run(J, 0, 1); run(J, 0, 2); run(J, 0, 12);
    run(JALOP, 0, 1); run(JALOP, 0, 2); run(JALOP, 0, 13);
    run(ADDI, 0, 1); run(ADDI, 0, 2); run(ADDI, 0, 10); run(ADDI, 0, 11);
    // fetch timeout, then retried fetch
    repeat (4) cyc(0, J, 0, 0, 1, 0);
    cyc(0, J, 0, 0, 15, 2'b10);
    run(J, 0, 1); run(J, 0, 2); run(J, 0, 12);
    // async reset while writing memory
    run(SW, 0, 1); run(SW, 0, 2); run(SW, 0, 3);
    cyc(0, SW, 0, 0, 6, 0);
    cyc(1, SW, 0, 0, 0, 0);
    cyc(0, SW, 0, 0, 0, 0);
    run(LW, 0, 1); run(LW, 0, 2); run(LW, 0, 3); run(LW, 0, 4); run(LW, 0, 5);
    run(LW, 0, 1);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
